// File: rtl/maxfinder_feeder.sv
// Operand assembler and result catcher in front of maxfinder: collects four words, starts
// the core, waits for done (with timeout) and streams the result out. Option: FP_SANITIZE_EN.
module maxfinder_feeder #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [31:0] eps_in,
    output logic [31:0] x1,
    output logic [31:0] x2,
    output logic [31:0] x3,
    output logic [31:0] x4,
    output logic [31:0] eps_out,
    output logic        mf_start,
    input  logic        mf_done,
    input  logic [31:0] mf_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_err,
    output logic        busy
`ifdef FP_SANITIZE_EN
    ,
    output logic        san_flag
`endif
);

    localparam logic [31:0]      QNAN     = 32'h7FC0_0000;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {COLLECT, START, WAIT, OUT} state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             capture_res, capture_to;
    logic             in_hs, out_hs;
    logic [31:0]      wr_data;

    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;

`ifdef FP_SANITIZE_EN
    logic wr_mod;
    logic san_acc;

    // NaN becomes -inf so it can never win the max; denormals flush to signed zero
    function automatic logic [32:0] sanitize(input logic [31:0] w);
        if (w[30:23] == 8'hFF && w[22:0] != 23'd0)
            return {1'b1, 32'hFF80_0000};
        else if (w[30:23] == 8'h00 && w[22:0] != 23'd0)
            return {1'b1, w[31], 31'd0};
        else
            return {1'b0, w};
    endfunction

    always_comb begin
        {wr_mod, wr_data} = sanitize(in_data);
    end
`else
    assign wr_data = in_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; the first WAIT cycle (cnt_q == 0) blanks a stale done level
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        capture_res = 1'b0;
        capture_to  = 1'b0;
        case (state_q)
            COLLECT: begin
                if (in_hs) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mf_done && cnt_q != '0) begin
                    capture_res = 1'b1;
                    state_d     = OUT;
                end else if (cnt_q == CNT_LAST) begin
                    capture_to = 1'b1;
                    state_d    = OUT;
                end
            end
            OUT: begin
                if (out_hs) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    // Registered outputs and data path
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b0;
            mf_start  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            x1        <= 32'h0;
            x2        <= 32'h0;
            x3        <= 32'h0;
            x4        <= 32'h0;
            eps_out   <= 32'h0;
            out_data  <= 32'h0;
            out_err   <= 1'b0;
`ifdef FP_SANITIZE_EN
            san_acc   <= 1'b0;
            san_flag  <= 1'b0;
`endif
        end else begin
            in_ready  <= (state_d == COLLECT);
            mf_start  <= (state_d == START);
            out_valid <= (state_d == OUT);
            busy      <= (state_d != COLLECT);
            if (in_hs) begin
                case (idx_q)
                    2'd0: x1 <= wr_data;
                    2'd1: x2 <= wr_data;
                    2'd2: x3 <= wr_data;
                    2'd3: begin
                        x4      <= wr_data;
                        eps_out <= eps_in;
                    end
                endcase
            end
            if (capture_res) begin
                out_data <= mf_result;
                out_err  <= 1'b0;
            end else if (capture_to) begin
                out_data <= QNAN;
                out_err  <= 1'b1;
            end
`ifdef FP_SANITIZE_EN
            if (out_hs)
                san_acc <= 1'b0;
            else if (in_hs && wr_mod)
                san_acc <= 1'b1;
            san_flag <= (state_d == OUT) && san_acc;
`endif
        end
    end

endmodule

// File: tb/tb_maxfinder_feeder.sv
// Scoreboard bench for maxfinder_feeder; the bench plays the maxfinder core itself.
module tb_maxfinder_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_data, eps_in;
    logic [31:0] x1, x2, x3, x4, eps_out;
    logic        mf_start, mf_done;
    logic [31:0] mf_result;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        out_err, busy;
`ifdef FP_SANITIZE_EN
    logic        san_flag;
`endif

    int          vectors     = 0;
    int          miscompares = 0;
    int          pushes      = 0;
    int          pops        = 0;
    logic [32:0] exp_q[$];

    maxfinder_feeder #(.TIMEOUT_CYCLES(255), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .eps_in(eps_in),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4), .eps_out(eps_out),
        .mf_start(mf_start), .mf_done(mf_done), .mf_result(mf_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .busy(busy)
`ifdef FP_SANITIZE_EN
        , .san_flag(san_flag)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: handshake happens at the next rising edge
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("out_data", out_data, e[31:0]);
                check("out_err", out_err, e[32]);
                pops++;
            end
        end
    end

    task automatic expect_result(input logic err, input logic [31:0] d);
        exp_q.push_back({err, d});
        pushes++;
    endtask

    task automatic feed_word(input logic [31:0] d, input logic [31:0] e);
        bit ok;
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        eps_in   = e;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 500);
        check("feed_accept", ok, 1);
        in_valid = 1'b0;
    endtask

    task automatic feed4(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] d, input logic [31:0] e, input bit gap);
        logic [31:0] w[4];
        w = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            feed_word(w[i], e);
            if (gap && i < 3) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Called just after the 4th handshake edge; leaves the bench in the first WAIT cycle
    task automatic start_check();
        check("start_hi", mf_start, 1);
        check("in_ready_start", in_ready, 0);
        check("busy_start", busy, 1);
        @(posedge clk);
        #1;
        check("start_lo", mf_start, 0);
        check("in_ready_wait", in_ready, 0);
    endtask

    // done seen at the end of the k-th WAIT cycle
    task automatic respond(input int k, input logic [31:0] res);
        repeat (k - 1) begin
            @(posedge clk);
            #1;
        end
        mf_done   = 1'b1;
        mf_result = res;
        @(posedge clk);
        #1;
        mf_done = 1'b0;
        check("out_valid_rise", out_valid, 1);
    endtask

    task automatic wait_drop();
        int n;
        n = 0;
        while (out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("out_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; eps_in = '0;
        mf_done = 1'b0; mf_result = '0; out_ready = 1'b1;
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_start", mf_start, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_x", {x1, x2}, 64'd0);
        check("rst_x34", {x3, x4}, 64'd0);
        check("rst_eps", eps_out, 0);
        check("rst_out", {out_err, out_data}, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_post_rst", in_ready, 1);

        // nominal run
        expect_result(1'b0, 32'h4100_0000);
        feed4(32'h3E20_0000, 32'hC060_0000, 32'h4100_0000, 32'hBF27_6C8B, 32'h3E4C_CCCD, 1'b0);
        start_check();
        check("nom_x1", x1, 32'h3E20_0000);
        check("nom_x2", x2, 32'hC060_0000);
        check("nom_x3", x3, 32'h4100_0000);
        check("nom_x4", x4, 32'hBF27_6C8B);
        check("nom_eps", eps_out, 32'h3E4C_CCCD);
        respond(2, 32'h4100_0000);
        wait_drop();

        // input backpressure, 5th word offered during WAIT
        expect_result(1'b0, 32'h4049_0FDB);
        feed4(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h3F00_0000, 1'b1);
        start_check();
        in_valid = 1'b1;
        in_data  = 32'h5555_5555;
        respond(3, 32'h4049_0FDB);
        check("bp_in_ready_out", in_ready, 0);
        check("bp_x1", x1, 32'h1111_1111);
        check("bp_x4", x4, 32'h4444_4444);
        check("bp_eps", eps_out, 32'h3F00_0000);
        wait_drop();

        // stale done blanking; 5th word becomes x1 of this run
        mf_done   = 1'b1;
        mf_result = 32'hDEAD_BEEF;
        expect_result(1'b0, 32'h3F80_0000);
        feed4(32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888, 32'h3DCC_CCCD, 1'b0);
        start_check();
        @(posedge clk);
        #1;
        mf_done = 1'b0;
        @(posedge clk);
        #1;
        mf_done   = 1'b1;
        mf_result = 32'h3F80_0000;
        @(posedge clk);
        #1;
        mf_done = 1'b0;
        check("stale_valid", out_valid, 1);
        check("stale_x1", x1, 32'h5555_5555);
        check("stale_x2", x2, 32'h6666_6666);
        wait_drop();

        // output backpressure
        out_ready = 1'b0;
        expect_result(1'b0, 32'hC2C8_0000);
        feed4(32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004, 32'h0000_0005, 1'b0);
        start_check();
        respond(4, 32'hC2C8_0000);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("obp_valid", out_valid, 1);
            check("obp_data", out_data, 32'hC2C8_0000);
            check("obp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("obp_drop", out_valid, 0);
        check("obp_collect", in_ready, 1);

        // timeout
        expect_result(1'b1, 32'h7FC0_0000);
        feed4(32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003, 32'hAAAA_0004, 32'h0, 1'b0);
        start_check();
        n = 0;
        while (!out_valid && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("timeout_cycles", 64'(n), 64'd255);
        wait_drop();

        // async reset during WAIT
        feed4(32'hBBBB_0001, 32'hBBBB_0002, 32'hBBBB_0003, 32'hBBBB_0004, 32'h1, 1'b0);
        start_check();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rw_start", mf_start, 0);
        check("rw_busy", busy, 0);
        check("rw_valid", out_valid, 0);
        check("rw_x1", x1, 0);
        check("rw_eps", eps_out, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        // async reset after two words, then a fresh run from x1
        feed_word(32'hCCCC_0001, 32'h0);
        feed_word(32'hCCCC_0002, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("rc_x1", x1, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        expect_result(1'b0, 32'h4000_0000);
        feed4(32'hDDDD_0001, 32'hDDDD_0002, 32'hDDDD_0003, 32'hDDDD_0004, 32'h3C23_D70A, 1'b0);
        start_check();
        check("fresh_x1", x1, 32'hDDDD_0001);
        check("fresh_x2", x2, 32'hDDDD_0002);
        check("fresh_x4", x4, 32'hDDDD_0004);
        check("fresh_eps", eps_out, 32'h3C23_D70A);
        respond(2, 32'h4000_0000);
        wait_drop();

`ifdef FP_SANITIZE_EN
        expect_result(1'b0, 32'h3F80_0000);
        feed4(32'h7FC0_0001, 32'h0000_0001, 32'h3F80_0000, 32'h8040_0000, 32'h0, 1'b0);
        start_check();
        check("san_x1", x1, 32'hFF80_0000);
        check("san_x2", x2, 32'h0000_0000);
        check("san_x3", x3, 32'h3F80_0000);
        check("san_x4", x4, 32'h8000_0000);
        respond(2, 32'h3F80_0000);
        check("san_flag_set", san_flag, 1);
        wait_drop();
        check("san_flag_clr", san_flag, 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        check("sb_pops", 64'(pops), 64'(pushes));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
